// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;

  // Arbiter control states: wait for a command, drive the memory, report back.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: picks the requester not served last on a tie.
// Latency: purely combinational.
// Backpressure: none; winner is only meaningful while req0|req1.
//
// Ports:
//   req0, req1 : pending requests
//   last       : port served most recently (0 or 1)
//   winner     : selected port (0 or 1)
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // Tie goes to the port not served last; a lone requester always wins.
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory, round-robin fair.
// Latency: gnt in cycle T, memory strobes in T+1, done/rdata in T+2.
// Backpressure: requesters hold req and fields until gnt; one op per 3 cycles.
//
// Ports:
//   clk, rst                    : clock, async active-low reset
//   req*/addr*/wdata*/rd*/wr*   : per-requester command
//   gnt*, done*, rdata*         : per-requester grant pulse, completion pulse, read result
//   mem_address/mem_writeData/mem_memRead/mem_memWrite, mem_readdata : memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          rd0,
  input  logic          wr0,

  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          rd1,
  input  logic          wr1,

  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,

  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writeData,
  output logic          mem_memRead,
  output logic          mem_memWrite,
  input  logic [DW-1:0] mem_readdata
);

  state_t        state_q;
  state_t        state_d;
  logic          grant;
  logic          winner;
  logic          owner_q;
  logic          last_q;
  logic          lat_rd_q;
  logic          lat_wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          done0_q;
  logic          done1_q;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (winner)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is combinational so the fields are captured on the same edge that
  // ends the gnt cycle. Gated by rst so a held request cannot show a grant
  // while the block is in reset.
  assign gnt0 = grant & ~winner & rst;
  assign gnt1 = grant &  winner & rst;

  // ---------------------------------------------------------------------------
  // Command capture and arbitration history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b1;   // port 0 wins the first tie after reset
      lat_rd_q <= 1'b0;
      lat_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (grant) begin
      owner_q  <= winner;
      last_q   <= winner;
      lat_rd_q <= winner ? rd1    : rd0;
      lat_wr_q <= winner ? wr1    : wr0;
      addr_q   <= winner ? addr1  : addr0;
      wdata_q  <= winner ? wdata1 : wdata0;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion: the memory answers on the negedge inside ACCESS, so its read
  // data is stable at the edge that moves us into RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (state_q == ACCESS) begin
        if (owner_q) begin
          done1_q <= 1'b1;
          if (lat_rd_q) rdata1_q <= mem_readdata;
        end else begin
          done0_q <= 1'b1;
          if (lat_rd_q) rdata0_q <= mem_readdata;
        end
      end
    end
  end

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  // Strobes decode straight from the state register, so an asynchronous
  // reset during ACCESS removes them before the memory's negedge.
  assign mem_memRead   = (state_q == ACCESS) & lat_rd_q;
  assign mem_memWrite  = (state_q == ACCESS) & lat_wr_q;
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a negedge-acting memory model.
// Latency: checks gnt at T, strobes at T+1, done/rdata at T+2.
// Backpressure: requesters hold req until gnt, then drop it.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, rd0, rd1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData;
  logic          mem_memRead, mem_memWrite;
  logic [DW-1:0] mem_readdata = '0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];
  logic [31:0] exp_rd0, exp_rd1;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .rd0          (rd0),
    .wr0          (wr0),
    .req1         (req1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .rd1          (rd1),
    .wr1          (wr1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .done0        (done0),
    .done1        (done1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .mem_address  (mem_address),
    .mem_writeData(mem_writeData),
    .mem_memRead  (mem_memRead),
    .mem_memWrite (mem_memWrite),
    .mem_readdata (mem_readdata)
  );

  // Word-addressed memory acting on the falling edge; read sees the old word.
  always @(negedge clk) begin
    if (mem_memRead)  mem_readdata = mem[mem_address[7:2]];
    if (mem_memWrite) mem[mem_address[7:2]] = mem_writeData;
  end

  typedef struct {
    logic        port;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;   // expected rdata of that port after done (if rd)
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
  endtask

  task automatic drive(input logic port, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      req1 = 1; rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1; rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = wdata;
    end
  endtask

  // Called right at a negedge with the DUT idle; returns at a later negedge.
  task automatic run_op(input vec_t v);
    drive(v.port, v.rd, v.wr, v.addr, v.wdata);
    #1;
    chk("gnt_T", {30'd0, gnt1, gnt0}, v.port ? 32'd2 : 32'd1);
    chk("strobe_T", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("gnt_T1", {30'd0, gnt1, gnt0}, 32'd0);
    chk("strobe_T1", {30'd0, mem_memRead, mem_memWrite}, {30'd0, v.rd, v.wr});
    chk("addr_T1", mem_address, v.addr);
    if (v.wr) chk("wdata_T1", mem_writeData, v.wdata);
    @(negedge clk);
    if (v.rd) begin
      if (v.port) exp_rd1 = v.exp_rdata;
      else        exp_rd0 = v.exp_rdata;
    end
    chk("done_T2", {30'd0, done1, done0}, v.port ? 32'd2 : 32'd1);
    chk("rdata0_T2", rdata0, exp_rd0);
    chk("rdata1_T2", rdata1, exp_rd1);
    chk("strobe_T2", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
    @(negedge clk);
    chk("done_T3", {30'd0, done1, done0}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          gcnt;
    logic        gport [0:15];
    int          gcyc  [0:15];

    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;

    //            port rd  wr  addr      wdata          exp_rdata
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h14, 32'h0,        32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        32'hA0000008};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h24, 32'h55AA55AA, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h24, 32'h0,        32'h55AA55AA};

    idle_inputs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    exp_rd0 = '0; exp_rd1 = '0;

    // Reset state, with a request already pending.
    rst = 0;
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_strobe", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_writeData, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

    // Single-requester table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_op(vecs[i]);
    end

    // Both requesters held continuously: alternate, port 0 first, 3 apart.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h34, 32'h0);
    gcnt = 0;
    for (int c = 0; c < 18; c++) begin
      #1;
      chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("done_excl", {31'd0, done0 & done1}, 32'd0);
      if ((gnt0 | gnt1) && gcnt < 16) begin
        gport[gcnt] = gnt1;
        gcyc[gcnt]  = c;
        gcnt++;
      end
      @(negedge clk);
    end
    idle_inputs();
    chk("rr_count", gcnt, 32'd6);
    for (int i = 0; i < gcnt && i < 6; i++) begin
      chk("rr_port", {31'd0, gport[i]}, i % 2);
      chk("rr_cycle", gcyc[i], 3 * i);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Reset during ACCESS of a write to 0x20 must suppress the write and done.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hBAD0BAD0);
    #1;
    chk("abort_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    chk("abort_pre_wr", {31'd0, mem_memWrite}, 32'd1);
    rst = 0;
    #1;
    chk("abort_strobe", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_done", {30'd0, done1, done0}, 32'd0);
    end
    rst = 1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    chk("abort_mem", mem[8], 32'hA0000008);
    @(negedge clk);
    run_op('{1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hA0000008});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DW, 32, data width of both requesters and the memory port.
REQ-002 SHALL have parameter AW, 32, byte-address width; the memory divides it by 4 internally.
REQ-003 SHALL have port clk, input, 1: single clock; every register updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 each: requester n has a command pending.
REQ-006 SHALL have ports addr0/addr1 (AW), wdata0/wdata1 (DW), rd0/rd1 (1), wr0/wr1 (1), all inputs: the command fields.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each: one-cycle pulse meaning requester n's command fields were latched.
REQ-008 SHALL have ports done0/done1, output, 1 each: one-cycle pulse meaning requester n's operation completed.
REQ-009 SHALL have ports rdata0/rdata1, output, DW each: read result, valid while donen=1 and held until the next read for that port.
REQ-010 SHALL have memory-side outputs mem_address (AW), mem_writeData (DW), mem_memRead (1), mem_memWrite (1), plus input mem_readdata (DW).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-012 In IDLE with req0|req1: pick the owner, latch that requester's addr/wdata/rd/wr, pulse gntn, go to ACCESS.
REQ-013 In IDLE with no request: stay in IDLE; all strobes are 0.
REQ-014 ACCESS SHALL drive the mem_* outputs from latched fields for exactly one cycle (the memory acts on negedge clk inside that cycle), then go to RESP.
REQ-015 On entering RESP, SHALL register mem_readdata into rdata<owner> if the latched rd=1, pulse done<owner>, and return to IDLE next cycle.
REQ-016 Fixed latency: gnt in cycle T, mem strobes in T+1, done and rdata in T+2; one operation per 3 cycles maximum.
REQ-017 Arbitration SHALL be round-robin: when both request, grant the port not served last; a single requester is granted regardless of history.
REQ-018 mem_memRead and mem_memWrite SHALL be 0 outside ACCESS; mem_address and mem_writeData hold their last values.
REQ-019 rd=1 and wr=1 together SHALL forward both strobes; the returned rdata is the pre-write word.
REQ-020 rd=0 and wr=0 SHALL still complete with done; rdata is unchanged.
REQ-021 A requester SHALL keep reqn high with stable fields until gntn; reqn high in the cycle after gntn is a new command.
REQ-022 gnt0&gnt1 and done0&done1 SHALL never be 1 simultaneously.

Reset
REQ-023 rst=0 SHALL force, immediately and asynchronously: state IDLE, gnt*/done*=0, rdata*=0, mem_memRead=mem_memWrite=0, mem_address=0, mem_writeData=0, last-served=port 1 (so port 0 wins the first tie).
REQ-024 Reset during ACCESS or RESP SHALL abort the operation with no done pulse; an abort in ACCESS before the negedge performs no memory write.

Structure
REQ-025 Package mem_arb_pkg SHALL hold the state enum typedef and the default DW/AW constants.
REQ-026 Two-way round-robin selection SHALL live in sub-module rr_pick2 (inputs req0, req1, last; output winner).

Verification
REQ-027 Reset release, req0=1 only, wr0=1, addr0=0x10, wdata0=0xDEADBEEF -> gnt0 at T, mem_memWrite=1 and mem_address=0x10 at T+1, done0 at T+2.
REQ-028 req0=1 only, rd0=1, addr0=0x10 after REQ-027 -> done0 at T+2 with rdata0=0xDEADBEEF; rdata1 remains 0.
REQ-029 req0 and req1 held high continuously -> grants alternate 0,1,0,1 with first grant to port 0, each 3 cycles apart.
REQ-030 Port 1 rd1=wr1=1, addr1=0x10, wdata1=0x12345678 -> rdata1=0xDEADBEEF at done1; a following read returns 0x12345678.
REQ-031 rst asserted in ACCESS of a write to 0x20 -> strobes drop in the same cycle, no done, and a later read of 0x20 returns the pre-test value.
